// File: rtl/snr_display_hold.sv
// snr_display_hold: block-average / peak-hold SNR conditioner feeding a 0..9999 display at a slow refresh rate
module snr_display_hold #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int UPDATE_HZ = 4,
  parameter int IN_W      = 16,
  parameter int AVG_LOG2  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic signed [IN_W-1:0] snr_in,
  input  logic                   snr_valid,
  input  logic                   peak_mode,
  output logic [15:0]            value,
  output logic                   value_updated,
  output logic                   signal_ok
);
  localparam int DIV = CLK_HZ / UPDATE_HZ;
  localparam int CW  = DIV > 1 ? $clog2(DIV) : 1;
  localparam int AW  = IN_W + AVG_LOG2;
  localparam int XW  = AW + 16;
  localparam logic signed [XW-1:0] MAXV = 9999;

  if (DIV < 2) begin : g_bad_div
    $error("snr_display_hold: CLK_HZ/UPDATE_HZ must be at least 2");
  end

  logic [CW-1:0]        div_cnt;
  logic                 tick;
  logic signed [AW-1:0] acc, sum, avg_reg;
  logic [AVG_LOG2-1:0]  cnt;
  logic signed [IN_W-1:0] peak_reg;
  logic                 peak_seen;
  logic signed [XW-1:0] peak_x, avg_x, cand;
  logic                 load;
  logic [15:0]          clamped;

  assign tick    = div_cnt == CW'(DIV - 1);
  assign sum     = acc + {{AVG_LOG2{snr_in[IN_W-1]}}, snr_in};
  assign peak_x  = {{(XW-IN_W){peak_reg[IN_W-1]}}, peak_reg};
  assign avg_x   = {{(XW-AW){avg_reg[AW-1]}}, avg_reg};

  always_comb begin
    cand    = peak_mode ? peak_x : avg_x;
    load    = tick & (peak_mode ? peak_seen : signal_ok);
    clamped = cand[XW-1] ? 16'd0 : cand > MAXV ? 16'd9999 : cand[15:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt       <= '0;
      value         <= '0;
      value_updated <= 1'b0;
      signal_ok     <= 1'b0;
      acc           <= '0;
      cnt           <= '0;
      avg_reg       <= '0;
      peak_reg      <= '0;
      peak_seen     <= 1'b0;
    end else begin
      div_cnt       <= tick ? '0 : div_cnt + 1'b1;
      value_updated <= load;
      if (load) value <= clamped;
      if (snr_valid) begin
        if (&cnt) begin
          avg_reg   <= sum >>> AVG_LOG2;
          acc       <= '0;
          cnt       <= '0;
          signal_ok <= 1'b1;
        end else begin
          acc <= sum;
          cnt <= cnt + 1'b1;
        end
      end
      // a sample in the tick cycle seeds the next peak window
      if (tick) begin
        peak_seen <= snr_valid;
        if (snr_valid) peak_reg <= snr_in;
      end else if (snr_valid && (!peak_seen || snr_in > peak_reg)) begin
        peak_reg  <= snr_in;
        peak_seen <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_snr_display_hold.sv
// tb_snr_display_hold: directed and random stimulus against a queue-based reference of the display conditioner
module tb_snr_display_hold;
  logic        clk = 0;
  logic        reset = 1;
  logic [15:0] snr_in = 0;
  logic        snr_valid = 0;
  logic        peak_mode = 0;
  logic [15:0] value;
  logic        value_updated;
  logic        signal_ok;

  snr_display_hold #(.CLK_HZ(100), .UPDATE_HZ(10), .IN_W(16), .AVG_LOG2(2)) dut (
    .clk(clk), .reset(reset), .snr_in(snr_in), .snr_valid(snr_valid),
    .peak_mode(peak_mode), .value(value), .value_updated(value_updated),
    .signal_ok(signal_ok)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors = 0;
  int cyc = 0;
  int blk[$];
  int win[$];
  int m_avg = 0;
  bit m_ok = 0;
  int exp_val = 0;
  bit exp_upd = 0;

  function automatic int floor_div4(int s);
    return (s < 0 && s % 4 != 0) ? s / 4 - 1 : s / 4;
  endfunction

  function automatic int clamp(int c);
    return c < 0 ? 0 : c > 9999 ? 9999 : c;
  endfunction

  task automatic chk(string tag, logic signed [31:0] obs, logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(bit r, bit v, int x, bit pm);
    int mx, s;
    reset = r; snr_valid = v; snr_in = x[15:0]; peak_mode = pm;
    @(posedge clk);
    if (r) begin
      blk.delete(); win.delete(); m_avg = 0; m_ok = 0; exp_val = 0; exp_upd = 0; cyc = 0;
    end else begin
      exp_upd = 0;
      if (cyc % 10 == 9) begin
        if (pm ? win.size() > 0 : m_ok) begin
          mx = -2147483647;
          foreach (win[i]) if (win[i] > mx) mx = win[i];
          exp_val = clamp(pm ? mx : m_avg);
          exp_upd = 1;
        end
        win.delete();
      end
      if (v) begin
        win.push_back(x);
        blk.push_back(x);
        if (blk.size() == 4) begin
          s = 0;
          foreach (blk[i]) s += blk[i];
          m_avg = floor_div4(s);
          m_ok = 1;
          blk.delete();
        end
      end
      cyc++;
    end
    #1;
    chk("value", value, exp_val);
    chk("value_updated", value_updated, exp_upd);
    chk("signal_ok", signal_ok, m_ok);
    chk("avg_reg", int'(dut.avg_reg), m_avg);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0);
    step(1, 1, 77, 1);
  endtask

  task automatic idle(int n, bit pm);
    for (int i = 0; i < n; i++) step(0, 0, 0, pm);
  endtask

  initial begin
    int pk_c[4] = '{1, 3, 5, 9};
    int pk_v[4] = '{12, 57, 8, 5};
    int avg_s[4] = '{10, 20, 30, 41};
    int neg_s[4] = '{-3, -3, -3, -2};
    logic [15:0] r16;
    bit v, pm, hit;
    int x;

    do_reset();
    idle(30, 0);

    do_reset();
    for (int i = 0; i < 4; i++) step(0, 1, avg_s[i], 0);
    idle(16, 0);
    chk("avg_value_25", value, 25);

    do_reset();
    for (int i = 0; i < 4; i++) step(0, 1, neg_s[i], 0);
    idle(12, 0);
    chk("neg_avg_reg", int'(dut.avg_reg), -3);

    do_reset();
    for (int c = 0; c < 36; c++) begin
      hit = 0; x = 0;
      for (int k = 0; k < 4; k++) if (pk_c[k] == c) begin hit = 1; x = pk_v[k]; end
      step(0, hit, x, 1);
      if (c == 9) chk("peak_57", value, 57);
      if (c == 19) chk("peak_5", value, 5);
      if (c == 29) chk("peak_hold_nopulse", value_updated, 0);
    end

    do_reset();
    for (int c = 0; c < 25; c++) begin
      step(0, c == 2 || c == 12, c == 2 ? 12000 : -32768, 1);
      if (c == 9) chk("sat_hi", value, 9999);
      if (c == 19) chk("sat_lo", value, 0);
    end

    do_reset();
    for (int i = 0; i < 3; i++) step(0, 1, 100 + i, 0);
    do_reset();
    step(0, 1, 500, 0);
    idle(25, 0);
    chk("mid_reset_ok", signal_ok, 0);

    do_reset();
    pm = 0;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 39) == 0) pm = ~pm;
      v = $urandom_range(0, 2) != 0;
      r16 = 16'($urandom);
      x = $urandom_range(0, 3) == 0 ? int'($signed(r16)) : $urandom_range(0, 250) - 50;
      step(0, v, x, pm);
      if (c == 400) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/snr_display_hold.md
# snr_display_hold

Rate-limiting conditioner that sits directly upstream of the 8-digit "SrdB" seven-segment display. It accepts a stream of signed integer SNR samples (dB) from the SNR estimator and forms a block average or a peak-hold over each refresh window. It clamps the result to the displayable range 0..9999 and drives the display's 16-bit `value` input at a human-readable update rate, so the digits do not flicker at sample rate.

## Interface
- `CLK_HZ`, 50_000_000: clock frequency in Hz.
- `UPDATE_HZ`, 4: display refresh rate; refresh period `DIV = CLK_HZ/UPDATE_HZ` cycles. Elaboration error if `DIV < 2`.
- `IN_W`, 16: width of the signed SNR sample.
- `AVG_LOG2`, 4: log2 of the block-average length; `N = 2**AVG_LOG2`.

- `clk`: input, 1 bit. Single clock; all logic on the rising edge.
- `reset`: input, 1 bit. Synchronous, active-high.
- `snr_in`: input, `IN_W` bits. Signed two's-complement SNR in dB, integer.
- `snr_valid`: input, 1 bit. One-cycle qualifier for `snr_in`; may be asserted on any cycle, including back-to-back cycles.
- `peak_mode`: input, 1 bit. 0 selects block average; 1 selects peak-hold. Sampled only on refresh ticks.
- `value`: output, 16 bits. Unsigned 0..9999, wired straight to the display.
- `value_updated`: output, 1 bit. One-cycle pulse in the cycle after `value` changes register.
- `signal_ok`: output, 1 bit. High once at least one average block has completed since reset.

## Operation
- **Refresh counter** `div_cnt`: counts 0..DIV-1 and wraps. `tick` is asserted combinationally when `div_cnt == DIV-1`.
- **Averager**: a signed accumulator of `IN_W+AVG_LOG2` bits plus a sample counter of `AVG_LOG2` bits.
  - Each valid sample is added to the accumulator.
  - On the N-th sample, `avg_reg <= (acc + snr_in) >>> AVG_LOG2`. This is an arithmetic shift, truncating toward minus infinity.
  - On that same cycle the accumulator clears to 0, the counter clears to 0, and `signal_ok <= 1`.
  - The averager is free-running and independent of `tick`; partial blocks are never output.
- **Peak tracker**: `peak_reg` (signed) and `peak_seen` flag.
  - A valid sample with `!peak_seen || snr_in > peak_reg` loads `peak_reg` and sets `peak_seen`.
- **On tick**, the candidate is selected as follows:
  - If `peak_mode=0`: candidate = `avg_reg`, used only if `signal_ok`; otherwise `value` holds.
  - If `peak_mode=1`: candidate = `peak_reg`, used only if `peak_seen`; otherwise `value` holds.
  - After selection, the peak window restarts.
- **Peak window restart**: `peak_seen` clears. If `snr_valid` is high in the tick cycle, that sample becomes the first sample of the new window: `peak_reg <= snr_in` and `peak_seen <= 1`.
- **Clamp**: candidate < 0 gives 0; candidate > 9999 gives 9999; otherwise the candidate's low 16 bits.
- `value` registers the clamped candidate. `value_updated` pulses on every tick that loads `value`, even if the loaded number equals the old one.
- **Reset**: `value=0`, `value_updated=0`, `signal_ok=0`, `div_cnt=0`, accumulator/counter/`avg_reg`=0, `peak_seen=0`.
  - Reset asserted mid-block discards the partial average and the peak window.
  - Reset overrides a coincident `tick` and a coincident `snr_valid`.

## Timing
- A tick occurs on the DIV-th cycle after reset release, then every DIV cycles.
- `value` and `value_updated` change on the clock edge that ends the tick cycle, giving 1-cycle latency from tick.
- Average completion in the same cycle as a tick: the tick uses the old `avg_reg`. The new average appears at the next tick.
- Sample in a tick cycle: it goes to the averager normally, and to the *next* peak window as described above.
- Accumulator cannot overflow: N samples of `IN_W` bits fit in `IN_W+AVG_LOG2` bits.
- Throughput: one sample per cycle sustained; no backpressure.

## Test plan
Use `CLK_HZ=100`, `UPDATE_HZ=10` (DIV=10) and `AVG_LOG2=2` unless noted.

- **Reset behaviour**: reset, then 30 idle cycles. Required: `value=0`, no `value_updated` pulses, `signal_ok=0`.
- **Average mode**: `peak_mode=0`; samples 10, 20, 30, 41 back-to-back right after reset. Required: `signal_ok` rises, `avg_reg=25`, then at the first tick `value=25` with a one-cycle `value_updated`.
- **Negative average**: samples -3, -3, -3, -2. Required: `avg_reg=-3` (arithmetic shift, not toward zero) and `value=0` after the tick.
- **Peak mode with boundary sample**: `peak_mode=1`; samples 12, 57, 8 within one window, plus sample 5 in the tick cycle. Required: `value=57` after that tick. If no further samples arrive, the next tick gives `value=5`; the following tick holds 5 with no pulse.
- **Saturation**: peak sample 12000, then sample -32768. Required: `value=9999` after the first tick and `value=0` after the second.
- **Reset mid-operation**: reset asserted after 3 of 4 average samples, then one more sample. Required: `signal_ok` stays 0, `value` stays 0, and the partial block is discarded.
